// File: rtl/multu_seq_unit_if.sv
// Controller-to-multiplier bus: funct/start/operands in, status, echo and HI/LO out.
interface multu_seq_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [5:0]       mul_ctl;
  logic             mul_start;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [5:0]       mul_back;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hilo_out;

  modport master (
    output mul_ctl, mul_start, src_a, src_b,
    input  mul_back, busy, done, hi, lo, hilo_out
  );

  modport slave (
    input  mul_ctl, mul_start, src_a, src_b,
    output mul_back, busy, done, hi, lo, hilo_out
  );
endinterface

// File: rtl/multu_seq_unit.sv
// Iterative shift-add multiplier with HI/LO result pair, one step per clock.
// Optional signed multiply (funct 24) enabled by defining MULT_SIGNED_EN.
module multu_seq_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CNT_W   = 6,
  parameter logic [5:0]  F_MULTU = 6'd25,
  parameter logic [5:0]  F_MFHI  = 6'd16,
  parameter logic [5:0]  F_MFLO  = 6'd18,
`ifdef MULT_SIGNED_EN
  parameter logic [5:0]  F_MULT  = 6'd24,
`endif
  parameter logic [5:0]  F_OPEN  = 6'b111111
) (
  input logic clk,
  input logic rst,
  multu_seq_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   counter;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   mcand;
  logic               pend;

  logic               start_c;
  logic               open_c;
  logic [WIDTH:0]     step_sum_c;
  logic [WIDTH-1:0]   load_a_c;
  logic [WIDTH-1:0]   load_b_c;
  logic [2*WIDTH-1:0] result_c;

`ifdef MULT_SIGNED_EN
  logic sign;
  logic is_signed_c;

  // Signed starts multiply magnitudes; the sign is reapplied at commit.
  always_comb begin
    is_signed_c = (bus.mul_ctl == F_MULT);
    start_c     = bus.mul_start && ((bus.mul_ctl == F_MULTU) || is_signed_c);
    load_a_c    = (is_signed_c && bus.src_a[WIDTH-1]) ? WIDTH'(-bus.src_a) : bus.src_a;
    load_b_c    = (is_signed_c && bus.src_b[WIDTH-1]) ? WIDTH'(-bus.src_b) : bus.src_b;
    result_c    = sign ? (2*WIDTH)'(-product) : product;
  end
`else
  always_comb begin
    start_c  = bus.mul_start && (bus.mul_ctl == F_MULTU);
    load_a_c = bus.src_a;
    load_b_c = bus.src_b;
    result_c = product;
  end
`endif

  // Add step keeps the carry so the following shift brings it into the upper half.
  always_comb begin
    open_c     = (bus.mul_ctl == F_OPEN);
    step_sum_c = (WIDTH+1)'(product[2*WIDTH-1:WIDTH]);
    if (product[0]) begin
      step_sum_c = step_sum_c + (WIDTH+1)'(mcand);
    end
  end

  always_comb begin
    if (bus.mul_ctl == F_MFHI) begin
      bus.hilo_out = bus.hi;
    end else if (bus.mul_ctl == F_MFLO) begin
      bus.hilo_out = bus.lo;
    end else begin
      bus.hilo_out = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      counter      <= '0;
      product      <= '0;
      mcand        <= '0;
      pend         <= 1'b0;
      bus.hi       <= '0;
      bus.lo       <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.mul_back <= '0;
`ifdef MULT_SIGNED_EN
      sign         <= 1'b0;
`endif
    end else begin
      // Every accepted code, including start and open, is echoed back.
      bus.mul_back <= bus.mul_ctl;
      if (start_c) begin
        mcand    <= load_a_c;
        product  <= {WIDTH'(0), load_b_c};
        counter  <= '0;
        pend     <= 1'b0;
        state    <= RUN;
        bus.busy <= 1'b1;
        bus.done <= 1'b0;
`ifdef MULT_SIGNED_EN
        sign     <= is_signed_c && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
`endif
      end else begin
        case (state)
          IDLE: begin
          end
          RUN: begin
            product <= {step_sum_c, product[WIDTH-1:1]};
            if (open_c) begin
              pend <= 1'b1;
            end
            if (counter == LAST) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              counter <= counter + CNT_W'(1);
            end
          end
          DONE: begin
            if (open_c || pend) begin
              bus.hi   <= result_c[2*WIDTH-1:WIDTH];
              bus.lo   <= result_c[WIDTH-1:0];
              pend     <= 1'b0;
              state    <= IDLE;
              bus.done <= 1'b0;
            end
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
